// File: rtl/digit_mux.sv
// digit_mux: time-multiplexed 4-digit hex scanner with dead-time gaps, frame-aligned display updates and leading-zero blanking
// Ports: clk rising-edge clock; reset async active-low;
//        load_valid/load_data/load_ready accept a 16-bit value into a one-deep pending buffer;
//        blank_lz enables leading-zero blanking; nib is the current digit's nibble;
//        an is the active-low anode vector; frame_tick pulses on the first cycle of digit 0.
module digit_mux #(
  parameter int DIV   = 12000,
  parameter int BLANK = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [3:0]  nib,
  output logic [3:0]  an,
  output logic        frame_tick
);
  localparam int CW = $clog2(DIV > BLANK ? DIV : BLANK);
  typedef enum logic {SHOW, GAP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] idx, idx_nx;
  logic [15:0] disp, pend;
  logic pend_v, slot_end, boundary, accept;
  logic [3:0] zero_hi;
  // zero_hi[k] is set when nibbles k..3 are all zero; digit 0 is never blanked
  assign zero_hi = {disp[15:12] == 4'h0, disp[15:8] == 8'h0, disp[15:4] == 12'h0, 1'b0};
  assign nib = disp[{idx, 2'b00} +: 4];
  assign an = (state == SHOW && !(blank_lz && zero_hi[idx])) ? ~(4'b0001 << idx) : 4'hF;
  always_comb begin
    slot_end = cnt == (state == SHOW ? CW'(DIV - 1) : CW'(BLANK - 1));
    state_nx = slot_end ? (state == SHOW ? GAP : SHOW) : state;
    cnt_nx = slot_end ? '0 : cnt + 1'b1;
    idx_nx = (slot_end && state == GAP) ? idx + 2'd1 : idx;
    // the GAP->SHOW edge wrapping idx 3->0 starts a new frame
    boundary = slot_end && state == GAP && idx == 2'd3;
    load_ready = !pend_v || boundary;
    accept = load_valid && load_ready;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= GAP;
      cnt <= '0;
      idx <= 2'd3;
      disp <= 16'h0000;
      pend <= 16'h0000;
      pend_v <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      idx <= idx_nx;
      frame_tick <= boundary;
      if (boundary && pend_v) disp <= pend;
      if (accept) pend <= load_data;
      // a same-edge accept refills the buffer the boundary just drained
      pend_v <= accept || (pend_v && !boundary);
    end
  end
endmodule

// File: tb/tb_digit_mux.sv
// tb_digit_mux: directed self-checking bench for digit_mux with DIV=4, BLANK=2 (frame of 24 cycles)
module tb_digit_mux;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_valid = 1'b0;
  logic blank_lz = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic load_ready, frame_tick;
  logic [3:0] nib, an;
  int vec = 0;
  int miss = 0;
  int cyc = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic m_pv = 1'b0;

  digit_mux #(.DIV(4), .BLANK(2)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .blank_lz(blank_lz), .nib(nib), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // cycle c after release: cycles 0..1 are the initial gap, frames start at 2+24n,
  // each slot is 4 lit cycles followed by 2 dark cycles
  task automatic check_now();
    int p, s;
    bit lit;
    logic [3:0] ea;
    p = cyc < 2 ? 0 : (cyc - 2) % 24;
    s = cyc < 2 ? 3 : p / 6;
    lit = cyc >= 2 && p % 6 < 4 && !(blank_lz && s > 0 && (m_disp >> (4 * s)) == 16'h0);
    ea = lit ? ~(4'b0001 << s) : 4'hF;
    chk("an", {12'h0, an}, {12'h0, ea});
    chk("nib", {12'h0, nib}, {12'h0, m_disp[4*s +: 4]});
    chk("frame_tick", {15'h0, frame_tick}, {15'h0, (cyc >= 2 && p == 0)});
  endtask

  task automatic next();
    bit be, acc;
    be = cyc >= 1 && (cyc - 1) % 24 == 0;
    chk("load_ready", {15'h0, load_ready}, {15'h0, (!m_pv || be)});
    acc = load_valid && (!m_pv || be);
    @(posedge clk);
    #2;
    cyc++;
    if (be && m_pv) begin
      m_disp = m_pend;
      m_pv = 1'b0;
    end
    if (acc) begin
      m_pend = load_data;
      m_pv = 1'b1;
    end
    check_now();
  endtask

  task automatic run(input int n);
    repeat (n) next();
  endtask

  task automatic chk_reset_vals();
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_nib", {12'h0, nib}, 16'h0000);
    chk("rst_tick", {15'h0, frame_tick}, 16'h0000);
    chk("rst_ready", {15'h0, load_ready}, 16'h0001);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk_reset_vals();
    reset = 1'b1;
    cyc = 0;
    check_now();
    run(48);
    blank_lz = 1'b1;
    run(24);
    blank_lz = 1'b0;
    run(5);
    load_valid = 1'b1;
    load_data = 16'hA3F0;
    next();
    load_valid = 1'b0;
    run(40);
    load_valid = 1'b1;
    load_data = 16'h0050;
    next();
    load_data = 16'h1234;
    for (int i = 0; i < 30 && (cyc - 2) % 24 != 0; i++) next();
    load_valid = 1'b0;
    blank_lz = 1'b1;
    run(34);
    blank_lz = 1'b0;
    load_valid = 1'b1;
    load_data = 16'hBEEF;
    next();
    load_valid = 1'b0;
    run(2);
    reset = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk);
    #2;
    chk_reset_vals();
    reset = 1'b1;
    cyc = 0;
    m_disp = 16'h0;
    m_pend = 16'h0;
    m_pv = 1'b0;
    check_now();
    run(30);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
